// File: rtl/mesi_isc_broad_cntl_n.sv
// Broadcast controller: pops snoop entries, snoops every CPU except the originator, then enables the originator.
// All outputs registered; a stalled broadcast is aborted after ACK_TIMEOUT quiet cycles.
module mesi_isc_broad_cntl_n #(
  parameter int N_CPUS           = 4,
  parameter int CBUS_CMD_WIDTH   = 3,
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 5,
  parameter int ACK_TIMEOUT      = 255,
  parameter int CPU_ID_WIDTH     = $clog2(N_CPUS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_CPUS-1:0]                  cbus_ack_array_i,
  input  logic                               fifo_status_empty_i,
  input  logic                               fifo_status_full_i,
  input  logic [BROAD_TYPE_WIDTH-1:0]        broad_snoop_type_i,
  input  logic [CPU_ID_WIDTH-1:0]            broad_snoop_cpu_id_i,
  input  logic [BROAD_ID_WIDTH-1:0]          broad_snoop_id_i,
  output logic [N_CPUS*CBUS_CMD_WIDTH-1:0]   cbus_cmd_array_o,
  output logic                               broad_fifo_rd_o,
  output logic                               busy_o,
  output logic [BROAD_ID_WIDTH-1:0]          cur_broad_id_o,
  output logic                               timeout_o,
  output logic                               drop_o
);

  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_WR_SNOOP = CBUS_CMD_WIDTH'(1);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_RD_SNOOP = CBUS_CMD_WIDTH'(2);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_WR    = CBUS_CMD_WIDTH'(3);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_RD    = CBUS_CMD_WIDTH'(4);
  localparam int                        TW           = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]             TO_LAST      = (ACK_TIMEOUT > 0) ? TW'(ACK_TIMEOUT - 1) : '0;
  localparam bit                        TO_EN        = (ACK_TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, SNOOP, ENABLE} state_t;

  state_t                state_q;
  logic [N_CPUS-1:0]     pend_q;
  logic [CPU_ID_WIDTH-1:0] orig_q;
  logic                  rd_q;
  logic [TW-1:0]         cnt_q;

  logic [N_CPUS-1:0]     pend_nxt;
  logic [N_CPUS-1:0]     pend_init;
  logic [N_CPUS-1:0]     orig_oh;
  logic                  orig_ack;
  logic                  honoured;
  logic                  to_hit;
  logic                  head_ok;
  logic                  head_rd;
  logic                  unused_full;

  assign unused_full = fifo_status_full_i;

  function automatic logic [N_CPUS*CBUS_CMD_WIDTH-1:0] fan(input logic [N_CPUS-1:0] m,
                                                           input logic [CBUS_CMD_WIDTH-1:0] c);
    fan = '0;
    for (int k = 0; k < N_CPUS; k++)
      if (m[k]) fan[k*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = c;
  endfunction

  always_comb begin
    pend_nxt = pend_q & ~cbus_ack_array_i;
    orig_oh  = '0;
    orig_oh[orig_q] = 1'b1;
    orig_ack = cbus_ack_array_i[orig_q];
    honoured = ((state_q == SNOOP) && |(cbus_ack_array_i & pend_q)) ||
               ((state_q == ENABLE) && orig_ack);
    // Fires on the edge where the quiet-cycle count would reach ACK_TIMEOUT.
    to_hit   = TO_EN && !honoured && (cnt_q == TO_LAST);
    head_rd  = (broad_snoop_type_i == BROAD_TYPE_WIDTH'(2));
    head_ok  = ((broad_snoop_type_i == BROAD_TYPE_WIDTH'(1)) || head_rd) &&
               (int'(broad_snoop_cpu_id_i) < N_CPUS);
    pend_init = '0;
    for (int k = 0; k < N_CPUS; k++)
      pend_init[k] = (k != int'(broad_snoop_cpu_id_i));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= IDLE;
      pend_q           <= '0;
      orig_q           <= '0;
      rd_q             <= 1'b0;
      cnt_q            <= '0;
      cbus_cmd_array_o <= '0;
      broad_fifo_rd_o  <= 1'b0;
      busy_o           <= 1'b0;
      cur_broad_id_o   <= '0;
      timeout_o        <= 1'b0;
      drop_o           <= 1'b0;
    end else begin
      broad_fifo_rd_o <= 1'b0;
      timeout_o       <= 1'b0;
      drop_o          <= 1'b0;
      case (state_q)
        IDLE: begin
          // The pop lands at the end of the rd cycle, so the head is not re-sampled then.
          if (!fifo_status_empty_i && !broad_fifo_rd_o) begin
            broad_fifo_rd_o <= 1'b1;
            cur_broad_id_o  <= broad_snoop_id_i;
            orig_q          <= broad_snoop_cpu_id_i;
            rd_q            <= head_rd;
            if (head_ok) begin
              state_q          <= SNOOP;
              busy_o           <= 1'b1;
              pend_q           <= pend_init;
              cnt_q            <= '0;
              cbus_cmd_array_o <= fan(pend_init, head_rd ? CMD_RD_SNOOP : CMD_WR_SNOOP);
            end else begin
              drop_o <= 1'b1;
            end
          end
        end
        SNOOP: begin
          if (to_hit) begin
            state_q          <= IDLE;
            busy_o           <= 1'b0;
            pend_q           <= '0;
            cnt_q            <= '0;
            cbus_cmd_array_o <= '0;
            timeout_o        <= 1'b1;
          end else begin
            pend_q <= pend_nxt;
            if (pend_nxt == '0) begin
              state_q          <= ENABLE;
              cnt_q            <= '0;
              cbus_cmd_array_o <= fan(orig_oh, rd_q ? CMD_EN_RD : CMD_EN_WR);
            end else begin
              cbus_cmd_array_o <= fan(pend_nxt, rd_q ? CMD_RD_SNOOP : CMD_WR_SNOOP);
              cnt_q            <= honoured ? '0 : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
            end
          end
        end
        ENABLE: begin
          if (orig_ack || to_hit) begin
            state_q          <= IDLE;
            busy_o           <= 1'b0;
            pend_q           <= '0;
            cnt_q            <= '0;
            cbus_cmd_array_o <= '0;
            timeout_o        <= !orig_ack;
          end else begin
            cnt_q <= (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesi_isc_broad_cntl_n.sv
// Bench for mesi_isc_broad_cntl_n: directed broadcast scenarios on 4- and 5-CPU instances,
// then random broadcasts checked against a transaction-level model of pending acks and quiet cycles.
module tb_mesi_isc_broad_cntl_n;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [3:0]  ack4 = '0;
  logic        empty4 = 1'b1;
  logic [1:0]  type4 = '0;
  logic [1:0]  cid4 = '0;
  logic [4:0]  id4 = '0;
  logic [11:0] cmd4;
  logic        rd4, busy4, to4, drop4;
  logic [4:0]  curid4;

  logic [4:0]  ack5 = '0;
  logic        empty5 = 1'b1;
  logic [1:0]  type5 = '0;
  logic [2:0]  cid5 = '0;
  logic [4:0]  id5 = '0;
  logic [14:0] cmd5;
  logic        rd5, busy5, to5, drop5;
  logic [4:0]  curid5;

  int total = 0;
  int bad = 0;
  int pops4 = 0;
  int p0;

  always #5 clk = ~clk;
  always @(negedge clk) if (rd4 === 1'b1) pops4++;

  mesi_isc_broad_cntl_n #(.N_CPUS(4), .ACK_TIMEOUT(8)) u_dut4 (
    .clk(clk), .rst(rst), .cbus_ack_array_i(ack4),
    .fifo_status_empty_i(empty4), .fifo_status_full_i(1'b0),
    .broad_snoop_type_i(type4), .broad_snoop_cpu_id_i(cid4), .broad_snoop_id_i(id4),
    .cbus_cmd_array_o(cmd4), .broad_fifo_rd_o(rd4), .busy_o(busy4),
    .cur_broad_id_o(curid4), .timeout_o(to4), .drop_o(drop4));

  mesi_isc_broad_cntl_n #(.N_CPUS(5), .ACK_TIMEOUT(8)) u_dut5 (
    .clk(clk), .rst(rst), .cbus_ack_array_i(ack5),
    .fifo_status_empty_i(empty5), .fifo_status_full_i(1'b0),
    .broad_snoop_type_i(type5), .broad_snoop_cpu_id_i(cid5), .broad_snoop_id_i(id5),
    .cbus_cmd_array_o(cmd5), .broad_fifo_rd_o(rd5), .busy_o(busy5),
    .cur_broad_id_o(curid5), .timeout_o(to5), .drop_o(drop5));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected command bus: code in every slice whose CPU is in the set.
  function automatic logic [11:0] fan4(input logic [3:0] m, input int code);
    logic [11:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) if (m[k]) v[3*k +: 3] = 3'(code);
    return v;
  endfunction

  initial begin
    // Reset with an entry already waiting: no pop may happen while rst=0.
    type4 = 2'd1; cid4 = 2'd2; id4 = 5'd5; empty4 = 1'b0;
    tick(); tick();
    chk("rst_cmd4", 32'(cmd4), 32'h0);
    chk("rst_rd4", 32'(rd4), 32'h0);
    chk("rst_busy4", 32'(busy4), 32'h0);
    chk("rst_id4", 32'(curid4), 32'h0);
    chk("rst_to4", 32'(to4), 32'h0);
    chk("rst_drop4", 32'(drop4), 32'h0);
    chk("rst_cmd5", 32'(cmd5), 32'h0);
    chk("rst_rd5", 32'(rd5), 32'h0);
    p0 = pops4;

    // WR from cpu 2, acks on separate cycles.
    rst = 1'b1;
    tick();
    chk("wr_pop", 32'(rd4), 32'h1);
    chk("wr_busy", 32'(busy4), 32'h1);
    chk("wr_id", 32'(curid4), 32'd5);
    chk("wr_cmd0", 32'(cmd4), 32'h209);
    empty4 = 1'b1;
    ack4 = 4'b0001; tick();
    chk("wr_cmd1", 32'(cmd4), 32'h208);
    chk("wr_rd_once", 32'(rd4), 32'h0);
    ack4 = 4'b0010; tick();
    chk("wr_cmd2", 32'(cmd4), 32'h200);
    ack4 = 4'b1000; tick();
    chk("wr_en", 32'(cmd4), 32'h0c0);
    chk("wr_en_busy", 32'(busy4), 32'h1);
    ack4 = 4'b0100; tick();
    chk("wr_done_cmd", 32'(cmd4), 32'h0);
    chk("wr_done_busy", 32'(busy4), 32'h0);
    chk("wr_pops", 32'(pops4 - p0), 32'd1);
    ack4 = '0;

    // RD from cpu 0, all snoopers ack together.
    type4 = 2'd2; cid4 = 2'd0; id4 = 5'd9; empty4 = 1'b0;
    tick();
    chk("rd_cmd", 32'(cmd4), 32'h490);
    chk("rd_id", 32'(curid4), 32'd9);
    empty4 = 1'b1; ack4 = 4'b1110; tick();
    chk("rd_en", 32'(cmd4), 32'h004);
    ack4 = 4'b0001; tick();
    chk("rd_done", 32'(busy4), 32'h0);
    ack4 = '0;

    // No acks: timeout after 8 cycles; a waiting entry is held off while busy.
    type4 = 2'd1; cid4 = 2'd1; id4 = 5'd20; empty4 = 1'b0;
    tick();
    chk("to_entry", 32'(cmd4), 32'h241);
    type4 = 2'd2; cid4 = 2'd3; id4 = 5'd7;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("to_nopop", 32'(rd4), 32'h0);
      chk("to_pulse", 32'(to4), 32'(i == 8));
      chk("to_busy", 32'(busy4), 32'(i != 8));
    end
    chk("to_cmd", 32'(cmd4), 32'h0);
    tick();
    chk("to_next_pop", 32'(rd4), 32'h1);
    chk("to_next_id", 32'(curid4), 32'd7);
    chk("to_next_cmd", 32'(cmd4), 32'h092);
    empty4 = 1'b1;

    // Spurious originator ack in SNOOP must not reset the quiet count.
    for (int i = 1; i <= 8; i++) begin
      ack4 = (i == 3) ? 4'b1000 : 4'b0000;
      tick();
      chk("sp_pulse", 32'(to4), 32'(i == 8));
      chk("sp_cmd", 32'(cmd4), (i == 8) ? 32'h0 : 32'h092);
    end
    ack4 = '0;

    // Reset while in ENABLE, with another entry queued.
    type4 = 2'd1; cid4 = 2'd1; id4 = 5'd12; empty4 = 1'b0;
    tick();
    type4 = 2'd2; cid4 = 2'd2; id4 = 5'd4;
    ack4 = 4'b1101; tick();
    chk("mr_en", 32'(cmd4), 32'h018);
    ack4 = '0; rst = 1'b0; tick();
    chk("mr_cmd", 32'(cmd4), 32'h0);
    chk("mr_busy", 32'(busy4), 32'h0);
    chk("mr_rd", 32'(rd4), 32'h0);
    chk("mr_id", 32'(curid4), 32'h0);
    rst = 1'b1; tick();
    chk("mr_pop", 32'(rd4), 32'h1);
    chk("mr_pop_id", 32'(curid4), 32'd4);
    chk("mr_pop_cmd", 32'(cmd4), 32'h412);
    empty4 = 1'b1; ack4 = 4'b1011; tick();
    chk("mr_en2", 32'(cmd4), 32'h100);
    ack4 = 4'b0100; tick();
    chk("mr_done", 32'(busy4), 32'h0);
    ack4 = '0;

    // Discards on the 5-CPU instance: NOP type, then cpu_id 5.
    type5 = 2'd0; cid5 = 3'd0; id5 = 5'd1; empty5 = 1'b0;
    tick();
    chk("dr_pop1", 32'(rd5), 32'h1);
    chk("dr_drop1", 32'(drop5), 32'h1);
    chk("dr_busy1", 32'(busy5), 32'h0);
    chk("dr_cmd1", 32'(cmd5), 32'h0);
    type5 = 2'd1; cid5 = 3'd5; id5 = 5'd2;
    tick();
    chk("dr_gap", 32'(rd5), 32'h0);
    tick();
    chk("dr_pop2", 32'(rd5), 32'h1);
    chk("dr_drop2", 32'(drop5), 32'h1);
    chk("dr_busy2", 32'(busy5), 32'h0);
    chk("dr_cmd2", 32'(cmd5), 32'h0);
    empty5 = 1'b1; tick();
    chk("dr_quiet", 32'(drop5), 32'h0);

    // Random broadcasts against the pending-set / quiet-cycle model.
    for (int b = 0; b < 40; b++) begin
      int typ, org, bid, pct, quiet, phase, code;
      logic [3:0] waiting, a;
      bit exp_to;
      typ = $urandom_range(0, 3); org = $urandom_range(0, 3);
      bid = $urandom_range(0, 31); pct = $urandom_range(5, 60);
      type4 = 2'(typ); cid4 = 2'(org); id4 = 5'(bid); empty4 = 1'b0;
      ack4 = 4'($urandom_range(0, 15));
      tick();
      empty4 = 1'b1;
      chk("r_pop", 32'(rd4), 32'h1);
      chk("r_id", 32'(curid4), 32'(bid));
      if (typ == 0 || typ == 3) begin
        chk("r_drop", 32'(drop4), 32'h1);
        chk("r_drop_busy", 32'(busy4), 32'h0);
        chk("r_drop_cmd", 32'(cmd4), 32'h0);
        ack4 = '0;
        tick();
        continue;
      end
      waiting = 4'hf & ~(4'b0001 << org);
      phase = 1; quiet = 0; exp_to = 1'b0;
      for (int c = 0; c < 100 && phase != 0; c++) begin
        if (phase == 1) code = (typ == 1) ? 1 : 2;
        else code = (typ == 1) ? 3 : 4;
        chk("r_cmd", 32'(cmd4), 32'(fan4((phase == 1) ? waiting : (4'b0001 << org), code)));
        chk("r_busy", 32'(busy4), 32'h1);
        chk("r_to_idle", 32'(to4), 32'h0);
        chk("r_rd", 32'(rd4), 32'(c == 0));
        a = '0;
        for (int k = 0; k < 4; k++) if ($urandom_range(0, 99) < pct) a[k] = 1'b1;
        ack4 = a;
        tick();
        if (phase == 1) begin
          if ((a & waiting) != 0) begin
            waiting = waiting & ~a;
            quiet = 0;
            if (waiting == 0) phase = 2;
          end else quiet++;
        end else begin
          if (a[org]) phase = 0;
          else quiet++;
        end
        if (quiet == 8) begin
          phase = 0;
          exp_to = 1'b1;
        end
      end
      ack4 = '0;
      chk("r_bound", 32'(phase), 32'h0);
      chk("r_end_to", 32'(to4), 32'(exp_to));
      chk("r_end_busy", 32'(busy4), 32'h0);
      chk("r_end_cmd", 32'(cmd4), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
